// File: rtl/state_seq_pkg.sv
// Shared codes for the training layer sequencer: main-state codes, layer codes,
// sequencer FSM states and the per-main-state step range decode.
package state_seq_pkg;

    localparam int STATE_LEN = 3;

    localparam logic [STATE_LEN-1:0] M_IDLE   = 3'd0;
    localparam logic [STATE_LEN-1:0] M_FF     = 3'd1;
    localparam logic [STATE_LEN-1:0] M_FB     = 3'd2;
    localparam logic [STATE_LEN-1:0] M_LB     = 3'd3;
    localparam logic [STATE_LEN-1:0] M_UPDATE = 3'd4;
    localparam logic [STATE_LEN-1:0] M_FIN    = 3'd5;

    localparam logic [2:0] L_EMB   = 3'd0;
    localparam logic [2:0] L_MIX   = 3'd1;
    localparam logic [2:0] L_DENSE = 3'd2;
    localparam logic [2:0] L_COMP  = 3'd3;
    localparam logic [2:0] L_UPD   = 3'd4;

    localparam logic [2:0] STEP_FWD_FIRST = 3'd0;
    localparam logic [2:0] STEP_FWD_LAST  = 3'd3;
    localparam logic [2:0] STEP_BWD_FIRST = 3'd4;
    localparam logic [2:0] STEP_BWD_LAST  = 3'd7;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_KICK  = 3'd1,
        S_LOAD  = 3'd2,
        S_ISSUE = 3'd3,
        S_WAIT  = 3'd4
    } seq_state_e;

    typedef enum logic [1:0] {
        MK_RANGE   = 2'd0,
        MK_FIN     = 2'd1,
        MK_IDLE    = 2'd2,
        MK_ILLEGAL = 2'd3
    } main_kind_e;

    typedef struct packed {
        main_kind_e kind;
        logic       upd;
        logic [2:0] first;
        logic [2:0] last;
    } main_decode_t;

    // M_UPDATE is a one-step range whose layer code is overridden to L_UPD.
    function automatic main_decode_t decode_main(input logic [STATE_LEN-1:0] m);
        main_decode_t d;
        d = '{kind: MK_ILLEGAL, upd: 1'b0, first: 3'd0, last: 3'd0};
        case (m)
            M_FF: begin
                d.kind  = MK_RANGE;
                d.first = STEP_FWD_FIRST;
                d.last  = STEP_FWD_LAST;
            end
            M_FB: begin
                d.kind  = MK_RANGE;
                d.first = STEP_FWD_FIRST;
                d.last  = STEP_BWD_LAST;
            end
            M_LB: begin
                d.kind  = MK_RANGE;
                d.first = STEP_BWD_FIRST;
                d.last  = STEP_BWD_LAST;
            end
            M_UPDATE: begin
                d.kind  = MK_RANGE;
                d.upd   = 1'b1;
                d.first = 3'd0;
                d.last  = 3'd0;
            end
            M_FIN:   d.kind = MK_FIN;
            M_IDLE:  d.kind = MK_IDLE;
            default: d.kind = MK_ILLEGAL;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/state_seq.sv
// Layer sequencer: walks each main state's layer step range, issuing one-cycle
// layer_run pulses and kicking the main state machine with main_run between ranges.
module state_seq
    import state_seq_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [STATE_LEN-1:0] main_q,
    input  logic                 layer_done,
    output logic                 main_run,
    output logic                 layer_run,
    output logic [2:0]           layer_q,
    output logic                 dir,
    output logic                 busy,
    output logic                 err,
    output seq_state_e           dbg_state
);

    // Pulse protocol: main_run and layer_run are single-cycle strobes with no
    // back-pressure; layer_done is a single-cycle strobe honoured only in S_WAIT
    // and dropped anywhere else, so nothing ever queues.
    seq_state_e   state_q;
    logic [2:0]   step_q;
    logic [2:0]   last_q;
    logic         upd_q;
    logic         main_run_q;
    logic         layer_run_q;
    logic [2:0]   layer_code_q;
    logic         dir_q;
    logic         busy_q;
    logic         err_q;

    main_decode_t dec;
    logic [2:0]   step_inc;

    function automatic logic [2:0] step_layer(input logic [2:0] step);
        logic [2:0] code;
        case (step)
            3'd0:    code = L_EMB;
            3'd1:    code = L_MIX;
            3'd2:    code = L_DENSE;
            3'd3:    code = L_COMP;
            3'd4:    code = L_COMP;
            3'd5:    code = L_DENSE;
            3'd6:    code = L_MIX;
            3'd7:    code = L_EMB;
            default: code = L_EMB;
        endcase
        return code;
    endfunction

    assign dec      = decode_main(main_q);
    assign step_inc = step_q + 3'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            step_q       <= 3'd0;
            last_q       <= 3'd0;
            upd_q        <= 1'b0;
            main_run_q   <= 1'b0;
            layer_run_q  <= 1'b0;
            layer_code_q <= 3'd0;
            dir_q        <= 1'b0;
            busy_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            main_run_q  <= 1'b0;
            layer_run_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start && (main_q == M_IDLE)) begin
                        state_q    <= S_KICK;
                        main_run_q <= 1'b1;
                        busy_q     <= 1'b1;
                    end
                end
                S_KICK: begin
                    state_q <= S_LOAD;
                end
                // main_q already shows the state entered on the preceding kick.
                S_LOAD: begin
                    case (dec.kind)
                        MK_RANGE: begin
                            state_q      <= S_ISSUE;
                            layer_run_q  <= 1'b1;
                            step_q       <= dec.first;
                            last_q       <= dec.last;
                            upd_q        <= dec.upd;
                            layer_code_q <= dec.upd ? L_UPD : step_layer(dec.first);
                            dir_q        <= dec.upd ? 1'b0 : dec.first[2];
                        end
                        MK_FIN: begin
                            state_q    <= S_KICK;
                            main_run_q <= 1'b1;
                        end
                        MK_IDLE: begin
                            state_q <= S_IDLE;
                            busy_q  <= 1'b0;
                        end
                        MK_ILLEGAL: begin
                            state_q <= S_IDLE;
                            busy_q  <= 1'b0;
                            err_q   <= 1'b1;
                        end
                    endcase
                end
                S_ISSUE: begin
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    if (layer_done) begin
                        // Compare before incrementing so step 7 never wraps to 0.
                        if (!upd_q && (step_q < last_q)) begin
                            state_q      <= S_ISSUE;
                            layer_run_q  <= 1'b1;
                            step_q       <= step_inc;
                            layer_code_q <= step_layer(step_inc);
                            dir_q        <= step_inc[2];
                        end else begin
                            state_q    <= S_KICK;
                            main_run_q <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign main_run  = main_run_q;
    assign layer_run = layer_run_q;
    assign layer_q   = layer_code_q;
    assign dir       = dir_q;
    assign busy      = busy_q;
    assign err       = err_q;
    assign dbg_state = state_q;

endmodule
